gpu_cmd_scheduler: RTL and testbench

Command scheduler between the CPU store path and the graphic processing unit's 32-bit instruction input. It buffers CPU-issued GPU commands in a small FIFO and issues them one at a time with a valid/ack handshake. Each command waits for the GPU's completion pulse before the next one issues. Commands flagged frame-synchronous are held until the next vertical-sync pulse, so drawing updates land between frames.

---
 rtl/gpu_cmd_scheduler.sv | 168 ++++++++++++++++
 tb/tb_gpu_cmd_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_cmd_scheduler.sv
// GPU command scheduler: buffers CPU commands in a FIFO and issues
// them one at a time to the GPU, holding frame-sync commands for V_SYNC.
module gpu_cmd_scheduler #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CMD_VALID,
  input  logic [31:0]              CMD_DATA,
  output logic                     CMD_READY,
  input  logic                     FLUSH,
  output logic [31:0]              INS,
  output logic                     INS_VALID,
  input  logic                     INS_ACK,
  input  logic                     GPU_DONE,
  input  logic                     V_SYNC,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic [15:0]              ISSUE_CNT,
  output logic                     ERR
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = 16;
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VSYNC,
    ISSUE,
    WAIT_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  logic [TW-1:0]   tcnt;
  logic [15:0]     issue_cnt;
  logic            err;
  logic            v_sync_q;
  logic            full;
  logic            push;
  logic            pop;
  logic            tmo;
  logic            vs_fall;
  logic [31:0]     head;

  assign full    = (level == LW'(DEPTH));
  assign push    = CMD_VALID & ~full & ~FLUSH;
  assign vs_fall = v_sync_q & ~V_SYNC;
  assign head    = mem[rd_ptr];

  assign CMD_READY = ~full;
  assign LEVEL     = level;
  assign ISSUE_CNT = issue_cnt;
  assign ERR       = err;
  assign INS_VALID = (state == ISSUE);
  assign INS       = (state == ISSUE) ? {1'b0, head[30:0]} : 32'd0;

  // Command storage; contents need no reset since level gates use.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= CMD_DATA;
    end
  end

  // FIFO pointers and occupancy; flush clears everything at once.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Next-state decode for the issue sequencer.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tmo       = 1'b0;
    unique case (state)
      IDLE: begin
        if (level != '0) begin
          state_nxt = head[31] ? WAIT_VSYNC : ISSUE;
        end
      end
      WAIT_VSYNC: begin
        if (vs_fall) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (INS_ACK) begin
          pop       = 1'b1;
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (GPU_DONE) begin
          state_nxt = IDLE;
        end else if (tcnt == TLIM) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else if (FLUSH) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Completion timeout counter, restarted on each accepted issue.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tcnt <= '0;
    end else if (pop) begin
      tcnt <= '0;
    end else if (state == WAIT_DONE) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // Issue counter survives flush; sticky error does not.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      issue_cnt <= '0;
      err       <= 1'b0;
    end else if (FLUSH) begin
      err       <= 1'b0;
    end else begin
      if (pop) issue_cnt <= issue_cnt + 1'b1;
      if (tmo) err <= 1'b1;
    end
  end

  // Previous V_SYNC level for falling-edge detection.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      v_sync_q <= 1'b1;
    end else begin
      v_sync_q <= V_SYNC;
    end
  end

endmodule

// File: tb/tb_gpu_cmd_scheduler.sv
// Bench for gpu_cmd_scheduler: directed scenarios followed by random
// traffic checked against a queue-based transaction model.
module tb_gpu_cmd_scheduler;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic [31:0]   cmd_data;
  logic          cmd_ready;
  logic          flush;
  logic [31:0]   ins;
  logic          ins_valid;
  logic          ins_ack;
  logic          gpu_done;
  logic          v_sync;
  logic [LW-1:0] level;
  logic [15:0]   issue_cnt;
  logic          err;

  int errors = 0;
  int checks = 0;
  logic [31:0] q[$];
  int cnt_m = 0;

  gpu_cmd_scheduler #(.DEPTH(DEPTH), .TIMEOUT(1023)) dut (
    .CLK(clk),
    .RST(rst_n),
    .CMD_VALID(cmd_valid),
    .CMD_DATA(cmd_data),
    .CMD_READY(cmd_ready),
    .FLUSH(flush),
    .INS(ins),
    .INS_VALID(ins_valid),
    .INS_ACK(ins_ack),
    .GPU_DONE(gpu_done),
    .V_SYNC(v_sync),
    .LEVEL(level),
    .ISSUE_CNT(issue_cnt),
    .ERR(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_ins"}, ins, 0);
    chk({tag, "_valid"}, ins_valid, 0);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_cnt"}, issue_cnt, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // One clock of random traffic: update the model for the coming edge,
  // advance, then compare against the model.
  task automatic step_model();
    bit acc;
    bit popv;
    acc  = cmd_valid && (q.size() < DEPTH);
    popv = ins_valid && ins_ack;
    if (popv && q.size() > 0) begin
      void'(q.pop_front());
      cnt_m++;
    end
    if (acc) q.push_back(cmd_data);
    tick();
    chk("rnd_level", level, q.size());
    chk("rnd_ready", cmd_ready, q.size() < DEPTH);
    chk("rnd_cnt", issue_cnt, cnt_m[15:0]);
    chk("rnd_err", err, 0);
    if (ins_valid) begin
      chk("rnd_valid_nonempty", q.size() != 0, 1);
      if (q.size() != 0) chk("rnd_ins", ins, {1'b0, q[0][30:0]});
    end else begin
      chk("rnd_ins_nop", ins, 0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    flush     = 1'b0;
    ins_ack   = 1'b0;
    gpu_done  = 1'b0;
    v_sync    = 1'b1;

    // Reset state.
    tick();
    tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick();

    // Single command, ack tied high, done one cycle after ack.
    ins_ack   = 1'b1;
    cmd_valid = 1'b1;
    cmd_data  = 32'h0000_00A5;
    tick();
    cmd_valid = 1'b0;
    chk("t1_valid_push", ins_valid, 0);
    chk("t1_level_push", level, 1);
    tick();
    chk("t1_valid_issue", ins_valid, 1);
    chk("t1_ins", ins, 32'h0000_00A5);
    tick();
    chk("t1_valid_after_ack", ins_valid, 0);
    chk("t1_cnt", issue_cnt, 1);
    chk("t1_level_after", level, 0);
    gpu_done = 1'b1;
    tick();
    gpu_done = 1'b0;
    ins_ack  = 1'b0;
    chk("t1_valid_done", ins_valid, 0);

    // Fill past capacity with ack held low.
    for (int i = 0; i < 9; i++) begin
      cmd_valid = 1'b1;
      cmd_data  = 32'h100 + i;
      tick();
      if (i == 6) chk("t2_ready_7", cmd_ready, 1);
      if (i == 7) begin
        chk("t2_ready_8", cmd_ready, 0);
        chk("t2_level_8", level, 8);
      end
    end
    cmd_valid = 1'b0;
    chk("t2_level_9", level, 8);
    chk("t2_ready_9", cmd_ready, 0);
    chk("t2_valid", ins_valid, 1);
    chk("t2_ins", ins, 32'h100);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t2_flush_level", level, 0);
    chk("t2_flush_cnt", issue_cnt, 1);

    // Frame-sync command held until V_SYNC falls.
    cmd_valid = 1'b1;
    cmd_data  = 32'h8000_0011;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t3_hold", ins_valid, 0);
    end
    v_sync = 1'b0;
    tick();
    v_sync = 1'b1;
    chk("t3_valid", ins_valid, 1);
    chk("t3_ins", ins, 32'h0000_0011);

    // Ack without done: timeout after 1023 cycles in WAIT_DONE.
    ins_ack = 1'b1;
    tick();
    ins_ack   = 1'b0;
    chk("t4_cnt", issue_cnt, 2);
    cmd_valid = 1'b1;
    cmd_data  = 32'h0000_0022;
    tick();
    cmd_valid = 1'b0;
    repeat (1021) tick();
    chk("t4_err_early", err, 0);
    chk("t4_valid_wait", ins_valid, 0);
    tick();
    chk("t4_err", err, 1);
    chk("t4_valid_idle", ins_valid, 0);
    chk("t4_level", level, 1);
    tick();
    chk("t4_next_valid", ins_valid, 1);
    chk("t4_next_ins", ins, 32'h0000_0022);

    // Flush with four queued and a push on the flush edge.
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1;
      cmd_data  = 32'h33 + 32'(i * 17);
      tick();
    end
    chk("t5_level", level, 4);
    chk("t5_valid", ins_valid, 1);
    chk("t5_err_sticky", err, 1);
    cmd_data = 32'h0000_0999;
    flush    = 1'b1;
    tick();
    flush     = 1'b0;
    cmd_valid = 1'b0;
    chk("t5_level_f", level, 0);
    chk("t5_valid_f", ins_valid, 0);
    chk("t5_ins_f", ins, 0);
    chk("t5_err_f", err, 0);
    chk("t5_cnt_f", issue_cnt, 2);
    chk("t5_ready_f", cmd_ready, 1);

    // Async reset while waiting for V_SYNC with three queued.
    for (int i = 1; i <= 3; i++) begin
      cmd_valid = 1'b1;
      cmd_data  = 32'h8000_0000 + i;
      tick();
    end
    cmd_valid = 1'b0;
    chk("t6_level", level, 3);
    chk("t6_valid", ins_valid, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t6");
    rst_n = 1'b1;
    tick();
    chk("t6_level_post", level, 0);
    v_sync = 1'b0;
    tick();
    v_sync = 1'b1;
    tick();
    chk("t6_no_retain", ins_valid, 0);

    // Random traffic against the transaction model.
    q.delete();
    cnt_m = 0;
    for (int n = 0; n < 2000; n++) begin
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_data  = $urandom;
      cmd_data[31] = ($urandom_range(0, 3) == 0);
      ins_ack   = ($urandom_range(0, 1) == 0);
      gpu_done  = ($urandom_range(0, 9) < 3);
      v_sync    = ($urandom_range(0, 9) != 0);
      step_model();
    end

    // Drain: everything queued must eventually issue.
    cmd_valid = 1'b0;
    ins_ack   = 1'b1;
    gpu_done  = 1'b1;
    for (int n = 0; n < 400 && q.size() != 0; n++) begin
      v_sync = n[0];
      step_model();
    end
    chk("drain_empty", q.size(), 0);
    chk("drain_level", level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
